// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the shared result signals
// and the memory-side strobe bus of mem_arbiter.
//   requester side : req0/rw0/addr0/wdata0/done0, req1/rw1/addr1/wdata1/done1,
//                    rdata, err, busy
//   memory side    : mem_address, mem_dataIn, mem_R_W, mem_EN (to memory),
//                    mem_dataOut, mem_MFC (from memory, MFC is asynchronous)
// slave  = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_dataIn;
  logic              mem_R_W;
  logic              mem_EN;
  logic [DATA_W-1:0] mem_dataOut;
  logic              mem_MFC;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    input  mem_dataOut, mem_MFC,
    output done0, done1, rdata, err, busy,
    output mem_address, mem_dataIn, mem_R_W, mem_EN
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    output mem_dataOut, mem_MFC,
    input  done0, done1, rdata, err, busy,
    input  mem_address, mem_dataIn, mem_R_W, mem_EN
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for a shared
// word memory with an asynchronous MFC completion handshake.
// Ports:
//   clk    - system clock, all logic on rising edge
//   reset  - synchronous active-high reset
//   bus    - mem_arbiter_if.slave: requester ports 0/1, rdata/err/busy, and
//            the memory address/data/R_W/EN strobe bus with MFC return
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner's command
// SETUP   | address/data/R_W presented, EN low, one cycle
// STROBE  | EN high, waiting for synchronised MFC or the timeout count
// RELEASE | EN low, waiting for synchronised MFC to drop
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Timeout fires on the edge where the count would reach TIMEOUT, so the
  // abort lands exactly TIMEOUT cycles after EN rises.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mfc_meta_q;
  logic              mfc_s_q;
  logic              pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mfc_meta_q <= 1'b0;
      mfc_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mfc_meta_q <= bus.mem_MFC;
      mfc_s_q    <= mfc_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    // On a tie the port not granted last wins; otherwise the lone requester.
    pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req0 || bus.req1) begin
          gnt_d   = pick;
          last_d  = pick;
          rw_d    = pick ? bus.rw1    : bus.rw0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (mfc_s_q) begin
          state_d = S_RELEASE;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          if (rw_q) rdata_d = bus.mem_dataOut;
        end else if (cnt_q >= TO_LAST) begin
          state_d = S_RELEASE;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          err_d   = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!mfc_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs come straight from the latched command, so they only move on
  // the IDLE->SETUP edge, never while EN is high.
  assign bus.mem_address = addr_q;
  assign bus.mem_dataIn  = wdata_q;
  assign bus.mem_R_W     = rw_q;
  assign bus.mem_EN      = (state_q == S_STROBE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    bit          rw;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    int          port;
    bit          chk_rd;
    logic [15:0] rd;
    bit          err;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   en_rises = 0;
  int   n_dones = 0;
  bit   mfc_en = 1'b1;
  cmd_t cq0[$];
  cmd_t cq1[$];
  exp_t sb[$];
  logic [15:0] mem [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: acts on EN rise, answers with a 10 ns MFC pulse 5 ns later.
  task automatic memory_model();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    forever begin
      @(posedge bus.mem_EN);
      if (bus.mem_R_W) bus.mem_dataOut = mem[bus.mem_address[7:0]];
      else mem[bus.mem_address[7:0]] = bus.mem_dataIn;
      if (mfc_en) begin
        #5 bus.mem_MFC = 1'b1;
        #10 bus.mem_MFC = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic        prev_en = 1'b0;
    logic [32:0] cap = '0;
    exp_t        e;
    int          port;
    forever begin
      @(negedge clk);
      if (bus.mem_EN && !prev_en) begin
        en_cyc = cyc;
        en_rises++;
        cap = {bus.mem_address, bus.mem_dataIn, bus.mem_R_W};
      end else if (bus.mem_EN) begin
        n_vec++;
        if ({bus.mem_address, bus.mem_dataIn, bus.mem_R_W} !== cap) begin
          n_err++;
          $display("FAIL bus_stable: got %h, required %h while EN high",
                   {bus.mem_address, bus.mem_dataIn, bus.mem_R_W}, cap);
        end
      end
      prev_en = bus.mem_EN;
      if (bus.done0 && bus.done1) begin
        n_vec++; n_err++;
        $display("FAIL both_done: got done0=1 done1=1, required at most one");
      end
      if (bus.done0 || bus.done1) begin
        n_dones++;
        port = bus.done1 ? 1 : 0;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done on port %0d, required none", port);
        end else begin
          e = sb.pop_front();
          if (port !== e.port) begin
            n_err++;
            $display("FAIL grant_order: got port %0d, required port %0d", port, e.port);
          end
          n_vec++;
          if (bus.err !== e.err) begin
            n_err++;
            $display("FAIL err_flag: got %b, required %b", bus.err, e.err);
          end
          if (e.chk_rd) begin
            n_vec++;
            if (bus.rdata !== e.rd) begin
              n_err++;
              $display("FAIL rdata: got %h, required %h", bus.rdata, e.rd);
            end
          end
          if (e.lat >= 0) begin
            n_vec++;
            if (cyc - en_cyc !== e.lat) begin
              n_err++;
              $display("FAIL done_latency: got %0d cycles, required %0d", cyc - en_cyc, e.lat);
            end
          end
        end
      end
    end
  endtask

  task automatic drive_port(input int port);
    cmd_t c;
    bit   got;
    forever begin
      if (port == 0) begin
        if (cq0.size() == 0) break;
        c = cq0.pop_front();
        bus.rw0 = c.rw; bus.addr0 = c.addr; bus.wdata0 = c.wdata; bus.req0 = 1'b1;
      end else begin
        if (cq1.size() == 0) break;
        c = cq1.pop_front();
        bus.rw1 = c.rw; bus.addr1 = c.addr; bus.wdata1 = c.wdata; bus.req1 = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        got = (port == 0) ? bus.done0 : bus.done1;
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL done_wait: port %0d got no done, required one within 300 cycles", port);
      end
    end
    if (port == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_pending: got %0d outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus.done0, bus.done1, bus.err, bus.busy, bus.mem_EN, bus.mem_R_W} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {bus.done0, bus.done1, bus.err, bus.busy, bus.mem_EN, bus.mem_R_W});
    end
    n_vec++;
    if ({bus.rdata, bus.mem_address, bus.mem_dataIn} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 0", {bus.rdata, bus.mem_address, bus.mem_dataIn});
    end
  endtask

  task automatic test_write_read();
    int t_req;
    cq0.push_back('{1'b0, 16'd5, 16'hBEEF});
    sb.push_back('{0, 1'b0, 16'h0, 1'b0, -1});
    t_req = cyc;
    drive_port(0);
    n_vec++;
    if (en_cyc - t_req !== 2) begin
      n_err++;
      $display("FAIL en_latency: got %0d cycles, required 2", en_cyc - t_req);
    end
    cq0.push_back('{1'b1, 16'd5, 16'h0});
    sb.push_back('{0, 1'b1, 16'hBEEF, 1'b0, -1});
    drive_port(0);
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.rdata !== 16'hBEEF || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rdata_hold: got rdata=%h busy=%b, required BEEF 0", bus.rdata, bus.busy);
    end
    check_sb_empty("write_read");
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cq0.push_back('{1'b0, 16'(16'h10 + i), 16'(16'hA000 + i)});
      cq1.push_back('{1'b0, 16'(16'h20 + i), 16'(16'hB000 + i)});
    end
    cq0.push_back('{1'b1, 16'h20, 16'h0});
    cq1.push_back('{1'b1, 16'h12, 16'h0});
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{0, 1'b0, 16'h0, 1'b0, -1});
      sb.push_back('{1, 1'b0, 16'h0, 1'b0, -1});
    end
    sb.push_back('{0, 1'b1, 16'hB000, 1'b0, -1});
    sb.push_back('{1, 1'b1, 16'hA002, 1'b0, -1});
    fork
      drive_port(0);
      drive_port(1);
    join
    repeat (4) @(negedge clk);
    check_sb_empty("tie");
  endtask

  task automatic test_back_to_back();
    int rises0;
    rises0 = en_rises;
    for (int i = 0; i < 4; i++) begin
      cq1.push_back('{1'b0, 16'(i), 16'(16'h1230 + i)});
      sb.push_back('{1, 1'b0, 16'h0, 1'b0, -1});
    end
    drive_port(1);
    n_vec++;
    if (en_rises - rises0 !== 4) begin
      n_err++;
      $display("FAIL b2b_strobes: got %0d EN pulses, required 4", en_rises - rises0);
    end
    cq0.push_back('{1'b1, 16'd3, 16'h0});
    cq0.push_back('{1'b1, 16'd0, 16'h0});
    sb.push_back('{0, 1'b1, 16'h1233, 1'b0, -1});
    sb.push_back('{0, 1'b1, 16'h1230, 1'b0, -1});
    drive_port(0);
    repeat (4) @(negedge clk);
    check_sb_empty("b2b");
  endtask

  task automatic test_timeout();
    mfc_en = 1'b0;
    cq0.push_back('{1'b1, 16'd5, 16'h0});
    sb.push_back('{0, 1'b1, 16'h1230, 1'b1, 31});
    drive_port(0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy);
    end
    mfc_en = 1'b1;
    cq1.push_back('{1'b1, 16'd5, 16'h0});
    sb.push_back('{1, 1'b1, 16'hBEEF, 1'b0, -1});
    drive_port(1);
    repeat (4) @(negedge clk);
    check_sb_empty("timeout");
  endtask

  task automatic test_reset_mid_op();
    int dones0;
    bit hit;
    mfc_en = 1'b0;
    dones0 = n_dones;
    bus.rw1 = 1'b0; bus.addr1 = 16'd9; bus.wdata1 = 16'h5555; bus.req1 = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = bus.mem_EN;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL strobe_wait: got no EN, required EN within 20 cycles");
    end
    reset = 1'b1;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.mem_EN !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: got EN=%b busy=%b, required 0 0", bus.mem_EN, bus.busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (n_dones !== dones0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d dones, required %0d", n_dones, dones0);
    end
    mfc_en = 1'b1;
    cq0.push_back('{1'b1, 16'd5, 16'h0});
    cq1.push_back('{1'b1, 16'h11, 16'h0});
    sb.push_back('{0, 1'b1, 16'hBEEF, 1'b0, -1});
    sb.push_back('{1, 1'b1, 16'hA001, 1'b0, -1});
    fork
      drive_port(0);
      drive_port(1);
    join
    repeat (4) @(negedge clk);
    check_sb_empty("reset_mid_op");
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_dataOut = '0;
    bus.mem_MFC = 1'b0;
    fork
      memory_model();
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
